alu_shift_pipe: RTL and testbench



---
 rtl/alu_shift_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_shift_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_pipe.sv
// ---------------------------------------------------------------------------
// alu_shift_pipe
//   Pipelined barrel shifter for the ALU operand-2 path. Supports LSL, LSR,
//   ASR, ROR and RRX with ARM-style carry-out. The shift is evaluated
//   combinationally on the input side. Its result then travels through
//   STAGES elastic register stages, so latency is STAGES cycles when there is
//   no stall.
//
// Parameters
//   WIDTH   data width (power of two, 4..64)
//   STAGES  number of register stages = latency (1..4)
//   TAGW    sideband tag width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous drop of all in-flight operations
//   in_valid / in_ready   input handshake
//   in_data, in_shamt     operand and 8-bit shift amount
//   in_op, in_cin, in_tag operation code, current C flag, sideband tag
//   out_valid / out_ready output handshake
//   out_data, out_cout    shifted result and carry-out
//   out_tag               tag of the presented result
// ---------------------------------------------------------------------------
module alu_shift_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAGW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_shamt,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout,
    output logic [TAGW-1:0]  out_tag
);

    localparam int unsigned LW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_LSL  = 3'b001,
        OP_LSR  = 3'b010,
        OP_ASR  = 3'b011,
        OP_RRX  = 3'b100,
        OP_ROR  = 3'b101
    } op_e;

    // -----------------------------------------------------------------------
    // Shift datapath
    // -----------------------------------------------------------------------
    logic [WIDTH:0]         lsl_w;
    logic [WIDTH:0]         lsr_w;
    logic signed [WIDTH:0]  asr_src;
    logic signed [WIDTH:0]  asr_w;
    logic [7:0]             asr_amt;
    logic [LW-1:0]          rot_m;
    logic [2*WIDTH-1:0]     ror_w;
    logic [WIDTH-1:0]       res_d;
    logic                   res_c;
    logic                   in_fire;

    always_comb begin
        // Each shift gets one extra bit. That bit collects the last bit shifted
        // out, which is the carry. Shifts of WIDTH or more fall out naturally.
        lsl_w   = {1'b0, in_data} << in_shamt;
        lsr_w   = {in_data, 1'b0} >> in_shamt;
        // ASR saturates at WIDTH: every result bit and the carry become the sign.
        asr_amt = (in_shamt >= 8'(WIDTH)) ? 8'(WIDTH) : in_shamt;
        asr_src = {in_data, 1'b0};
        asr_w   = asr_src >>> asr_amt;
        // The rotate uses n mod W. The carry is always the new MSB. This also
        // covers the case m == 0 with n != 0.
        rot_m   = in_shamt[LW-1:0];
        ror_w   = {in_data, in_data} >> rot_m;

        res_d = in_data;
        res_c = in_cin;
        case (in_op)
            OP_LSL: if (in_shamt != '0) begin
                res_d = lsl_w[WIDTH-1:0];
                res_c = lsl_w[WIDTH];
            end
            OP_LSR: if (in_shamt != '0) begin
                res_d = lsr_w[WIDTH:1];
                res_c = lsr_w[0];
            end
            OP_ASR: if (in_shamt != '0) begin
                res_d = asr_w[WIDTH:1];
                res_c = asr_w[0];
            end
            OP_ROR: if (in_shamt != '0) begin
                res_d = ror_w[WIDTH-1:0];
                res_c = ror_w[WIDTH-1];
            end
            OP_RRX: begin
                res_d = {in_cin, in_data[WIDTH-1:1]};
                res_c = in_data[0];
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Elastic pipeline. Each stage owns its registers, so no vector is
    // driven from several processes. A stage may load when it is empty or
    // when its downstream neighbour is taking its content in the same cycle.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v;
        logic             c;
        logic [WIDTH-1:0] d;
        logic [TAGW-1:0]  t;
        logic             r;
        logic             pv;
        logic             pc;
        logic [WIDTH-1:0] pd;
        logic [TAGW-1:0]  pt;

        if (k == 0) begin : g_src
            assign pv = in_fire;
            assign pd = res_d;
            assign pc = res_c;
            assign pt = in_tag;
        end else begin : g_src
            assign pv = g_stage[k-1].v;
            assign pd = g_stage[k-1].d;
            assign pc = g_stage[k-1].c;
            assign pt = g_stage[k-1].t;
        end

        if (k == STAGES - 1) begin : g_rdy
            assign r = ~v | out_ready;
        end else begin : g_rdy
            assign r = ~v | g_stage[k+1].r;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                c <= 1'b0;
                d <= '0;
                t <= '0;
            end else if (flush) begin
                v <= 1'b0;
            end else if (r) begin
                v <= pv;
                if (pv) begin
                    d <= pd;
                    c <= pc;
                    t <= pt;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].r & ~flush;
    assign in_fire   = in_valid & in_ready;

    assign out_valid = g_stage[STAGES-1].v;
    assign out_data  = g_stage[STAGES-1].d;
    assign out_cout  = g_stage[STAGES-1].c;
    assign out_tag   = g_stage[STAGES-1].t;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_shift_pipe
//   Directed bench for alu_shift_pipe with WIDTH=32, STAGES=2, TAGW=4. It
//   applies a table of shift vectors with hand-computed results. It then runs
//   hand-written sequences for reset, backpressure, flush and asynchronous
//   reset while the pipe is full.
// ---------------------------------------------------------------------------
module tb_alu_shift_pipe;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] LSL  = 3'b001;
    localparam logic [2:0] LSR  = 3'b010;
    localparam logic [2:0] ASR  = 3'b011;
    localparam logic [2:0] RRX  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] RSV  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_shamt;
    logic [2:0]  in_op;
    logic        in_cin;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_cout;
    logic [3:0]  out_tag;

    int checks = 0;
    int errors = 0;

    alu_shift_pipe #(.WIDTH(32), .STAGES(2), .TAGW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [7:0]  n;
        logic        cin;
        logic [31:0] r;
        logic        c;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [7:0] n,
                         input logic cin, input logic [3:0] tg);
        in_op    = op;
        in_data  = a;
        in_shamt = n;
        in_cin   = cin;
        in_tag   = tg;
    endtask

    // The vector is presented in one cycle and accepted at the next rising
    // edge. After one more edge the result must be at the output.
    task automatic apply(input vec_t v, input logic [3:0] tg, input string nm);
        @(negedge clk);
        drive(v.op, v.a, v.n, v.cin, tg);
        in_valid = 1'b1;
        #1 chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({nm, ".early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk({nm, ".valid"}, 64'(out_valid), 64'd1);
        chk({nm, ".data"},  64'(out_data),  64'(v.r));
        chk({nm, ".cout"},  64'(out_cout),  64'(v.c));
        chk({nm, ".tag"},   64'(out_tag),   64'(tg));
    endtask

    initial begin
        int unsigned next_tag;
        int unsigned exp_tag;
        int          last_pop;
        logic        stall_prev;
        logic [31:0] sv_data;
        logic [3:0]  sv_tag;
        logic        sv_cout;

        vt[0]  = '{LSL,  32'h80000001, 8'd1,   1'b0, 32'h00000002, 1'b1};
        vt[1]  = '{ASR,  32'h80000000, 8'd4,   1'b0, 32'hF8000000, 1'b0};
        vt[2]  = '{ROR,  32'h00000001, 8'd1,   1'b0, 32'h80000000, 1'b1};
        vt[3]  = '{RRX,  32'h00000003, 8'd0,   1'b1, 32'h80000001, 1'b1};
        vt[4]  = '{LSR,  32'h80000000, 8'd32,  1'b0, 32'h00000000, 1'b1};
        vt[5]  = '{LSR,  32'h80000000, 8'd33,  1'b1, 32'h00000000, 1'b0};
        vt[6]  = '{ASR,  32'h80000000, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1};
        vt[7]  = '{ROR,  32'h12345678, 8'd64,  1'b1, 32'h12345678, 1'b0};
        vt[8]  = '{LSL,  32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1};
        vt[9]  = '{LSL,  32'h00000001, 8'd32,  1'b0, 32'h00000000, 1'b1};
        vt[10] = '{LSL,  32'hFFFFFFFF, 8'd33,  1'b1, 32'h00000000, 1'b0};
        vt[11] = '{LSR,  32'h000000F0, 8'd4,   1'b1, 32'h0000000F, 1'b0};
        vt[12] = '{ROR,  32'h12345678, 8'd4,   1'b0, 32'h81234567, 1'b1};
        vt[13] = '{ROR,  32'h12345678, 8'd36,  1'b0, 32'h81234567, 1'b1};
        vt[14] = '{NONE, 32'hDEADBEEF, 8'd5,   1'b1, 32'hDEADBEEF, 1'b1};
        vt[15] = '{RSV,  32'hDEADBEEF, 8'd5,   1'b0, 32'hDEADBEEF, 1'b0};
        vt[16] = '{ASR,  32'h40000000, 8'd32,  1'b1, 32'h00000000, 1'b0};
        vt[17] = '{ASR,  32'h80000010, 8'd5,   1'b0, 32'hFC000000, 1'b1};
        vt[18] = '{LSL,  32'h00000003, 8'd31,  1'b0, 32'h80000000, 1'b1};
        vt[19] = '{RRX,  32'h00000002, 8'd7,   1'b0, 32'h00000001, 1'b0};

        // ---------------- reset with in_valid held high ----------------
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        drive(LSL, 32'hFFFFFFFF, 8'd1, 1'b1, 4'hF);
        repeat (3) @(negedge clk);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.data",  64'(out_data),  64'd0);
        chk("rst.cout",  64'(out_cout),  64'd0);
        chk("rst.tag",   64'(out_tag),   64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("rst.in_ready", 64'(in_ready), 64'd1);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 20; i++) begin
            apply(vt[i], 4'(i), $sformatf("vec%0d", i));
        end

        // ---------------- backpressure ----------------
        // Tags 1..6 are offered back-to-back. The consumer stalls in cycles 3..6.
        @(negedge clk);
        next_tag = 1; exp_tag = 1; last_pop = -1; stall_prev = 1'b0;
        sv_data = '0; sv_tag = '0; sv_cout = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c != 0) @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (next_tag <= 6);
            drive(LSL, 32'(next_tag), 8'd1, 1'b0, 4'(next_tag));
            #1;
            if (c == 4) chk("bp.in_ready_full", 64'(in_ready), 64'd0);
            if (stall_prev) begin
                chk("bp.stall_data", 64'(out_data), 64'(sv_data));
                chk("bp.stall_tag",  64'(out_tag),  64'(sv_tag));
                chk("bp.stall_cout", 64'(out_cout), 64'(sv_cout));
            end
            if (out_valid && out_ready) begin
                chk("bp.tag",  64'(out_tag),  64'(exp_tag));
                chk("bp.data", 64'(out_data), 64'(exp_tag * 2));
                if (exp_tag >= 3) chk("bp.gap", 64'(c - last_pop), 64'd1);
                last_pop = c;
                exp_tag++;
            end
            stall_prev = out_valid && !out_ready;
            sv_data = out_data; sv_tag = out_tag; sv_cout = out_cout;
            if (in_valid && in_ready) next_tag++;
        end
        in_valid = 1'b0;
        chk("bp.count", 64'(exp_tag), 64'd7);

        // ---------------- flush ----------------
        @(negedge clk);
        out_ready = 1'b0;
        drive(LSL, 32'h7, 8'd1, 1'b0, 4'd7); in_valid = 1'b1;
        @(negedge clk);
        drive(LSL, 32'h8, 8'd1, 1'b0, 4'd8);
        @(negedge clk);
        drive(LSL, 32'h9, 8'd1, 1'b0, 4'd9);
        flush = 1'b1;
        #1;
        chk("fl.in_ready", 64'(in_ready), 64'd0);
        chk("fl.full", 64'(out_valid), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("fl.cleared", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("fl.none", 64'(out_valid), 64'd0);
        end
        apply(vt[3], 4'd10, "fl.next");

        // ---------------- async reset with a full pipe ----------------
        @(negedge clk);
        out_ready = 1'b0;
        drive(ROR, 32'h1, 8'd1, 1'b0, 4'd11); in_valid = 1'b1;
        @(negedge clk);
        drive(ROR, 32'h2, 8'd1, 1'b0, 4'd12);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("ar.full", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid_drop", 64'(out_valid), 64'd0);
        chk("ar.data_clr",   64'(out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("ar.no_stale", 64'(out_valid), 64'd0);
        end
        apply(vt[0], 4'd13, "ar.next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
